// File: rtl/trigger_capture_ctrl.sv
// Trigger-centred acquisition sequencer: pre-trigger fill, trigger wait, post-trigger capture, streamed readout.
// Optional `define AUTO_TRIG_EN adds a TIMEOUT-cycle forced trigger while ARMED.
module trigger_capture_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int PRE_SAMPLES = 256,
  parameter int HOLDOFF     = 16,
  parameter int TIMEOUT     = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        continuous,
  input  logic [13:0] adc_in,
  input  logic        trig_in,
  output logic [13:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        triggered,
  output logic [2:0]  state_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  RD_END    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_SAMPLES);

  if (PRE_SAMPLES < 1 || PRE_SAMPLES >= DEPTH || HOLDOFF < 1 || TIMEOUT < 1) begin : g_param_check
    $error("trigger_capture_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_en;
  logic              fire;
  logic [13:0]       ram [DEPTH];

  assign state_o = state;
  assign wr_en   = (state == S_PRELOAD) || (state == S_ARMED) || (state == S_POST);

`ifdef AUTO_TRIG_EN
  logic [31:0] to_cnt;

  // Counts ARMED cycles; the TIMEOUT-th one fires even without trig_in.
  always_ff @(posedge clk) begin
    if (rst || state != S_ARMED) to_cnt <= '0;
    else                         to_cnt <= to_cnt + 1'b1;
  end

  assign fire = trig_in || (to_cnt == 32'(TIMEOUT - 1));
`else
  assign fire = trig_in;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= adc_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_addr   <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      triggered <= 1'b0;
    end else begin
      triggered <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (arm) begin
            state <= S_PRELOAD;
            busy  <= 1'b1;
          end
        end
        S_PRELOAD: begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt    <= cnt + 1'b1;
          if (cnt == PRE_LAST) begin
            state <= S_ARMED;
            cnt   <= '0;
          end
        end
        S_ARMED: begin
          wr_ptr <= wr_ptr + 1'b1;
          // The trigger address is only needed as the readout start, so latch that directly.
          if (fire) begin
            rd_addr   <= wr_ptr - PRE_OFS;
            triggered <= 1'b1;
            if (POST_LAST == '0) begin
              state <= S_READOUT;
              cnt   <= '0;
            end else begin
              state <= S_POST;
              cnt   <= CNT_W'(1);
            end
          end
        end
        S_POST: begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt    <= cnt + 1'b1;
          if (cnt == POST_LAST) begin
            state <= S_READOUT;
            cnt   <= '0;
          end
        end
        S_READOUT: begin
          // The RAM output register doubles as the output stage: it reloads whenever empty or drained.
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cnt       <= '0;
            if (continuous) begin
              state <= S_HOLDOFF;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else if ((!out_valid || out_ready) && cnt != RD_END) begin
            out_data  <= ram[rd_addr];
            out_valid <= 1'b1;
            out_last  <= (cnt == RD_LAST);
            rd_addr   <= rd_addr + 1'b1;
            cnt       <= cnt + 1'b1;
          end
        end
        S_HOLDOFF: begin
          cnt <= cnt + 1'b1;
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (continuous) begin
              state <= S_PRELOAD;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Bench for trigger_capture_ctrl: directed frames plus random traffic against a frame-level reference model.
// Define AUTO_TRIG_EN for both files to exercise the forced-trigger build.
module tb_trigger_capture_ctrl;

  localparam int ADDR_W = 4, DEPTH = 16, PRE_SAMPLES = 4, HOLDOFF = 2, TIMEOUT = 20;
`ifdef AUTO_TRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int ST_IDLE = 0, ST_PRE = 1, ST_ARM = 2, ST_POST = 3, ST_RO = 4, ST_HOLD = 5;

  logic        clk = 1'b0;
  logic        rst, arm, continuous, trig_in, out_ready;
  logic [13:0] adc_in, out_data;
  logic        out_valid, out_last, busy, triggered;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  trigger_capture_ctrl #(
    .ADDR_W(ADDR_W), .PRE_SAMPLES(PRE_SAMPLES), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .continuous(continuous), .adc_in(adc_in),
    .trig_in(trig_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .triggered(triggered), .state_o(state_o)
  );

  int checks = 0, failures = 0;
  int m_state = ST_IDLE, m_n = 0, m_to = 0, m_ro_n = 0, m_ro_cyc = 0, m_frames = 0;
  bit m_trig = 0, m_seen_valid = 0;
  logic [13:0] hist[$], frame_q[$], got[$];
  bit got_last[$];
  bit prev_in_ro = 0, prev_valid = 0, prev_last = 0, prev_ready = 0;
  logic [13:0] prev_data = '0;
  int hold_cycles, armed_cycles, trig_pulses;

  task automatic compare(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: tracks phase lengths and the sample set that must come out, not the RTL's pointers.
  task automatic model_step(input bit a_arm, a_cont, a_trig, a_rst, input logic [13:0] a_adc, input bit hs);
    m_trig = 0;
    if (a_rst) begin
      m_state = ST_IDLE; m_n = 0; hist.delete(); frame_q.delete();
      return;
    end
    case (m_state)
      ST_IDLE: if (a_arm) begin m_state = ST_PRE; m_n = 0; hist.delete(); end
      ST_PRE: begin
        hist.push_back(a_adc);
        m_n++;
        if (m_n == PRE_SAMPLES) begin m_state = ST_ARM; m_to = 0; end
      end
      ST_ARM: begin
        m_to++;
        if (a_trig || (AUTO && m_to == TIMEOUT)) begin
          frame_q = hist;
          frame_q.push_back(a_adc);
          m_trig = 1;
          m_n = DEPTH - PRE_SAMPLES - 1;
          if (m_n == 0) begin m_state = ST_RO; m_ro_n = 0; m_ro_cyc = 0; m_seen_valid = 0; end
          else m_state = ST_POST;
        end else begin
          hist.push_back(a_adc);
          if (hist.size() > PRE_SAMPLES) hist.delete(0);
        end
      end
      ST_POST: begin
        frame_q.push_back(a_adc);
        m_n--;
        if (m_n == 0) begin m_state = ST_RO; m_ro_n = 0; m_ro_cyc = 0; m_seen_valid = 0; end
      end
      ST_RO: begin
        m_ro_cyc++;
        if (hs) begin
          if (frame_q.size() > 0) frame_q.delete(0);
          m_ro_n++;
          if (m_ro_n == DEPTH) begin
            m_frames++;
            m_n = 0;
            m_state = a_cont ? ST_HOLD : ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        m_n++;
        if (m_n == HOLDOFF) begin
          m_n = 0;
          hist.delete();
          m_state = a_cont ? ST_PRE : ST_IDLE;
        end
      end
      default: m_state = ST_IDLE;
    endcase
  endtask

  task automatic checkOutput();
    compare("state", state_o, m_state);
    compare("busy", busy, m_state != ST_IDLE);
    compare("triggered", triggered, m_trig);
    if (m_state != ST_RO) begin
      compare("valid_outside_readout", out_valid, 0);
      compare("last_outside_readout", out_last, 0);
    end else begin
      if (prev_in_ro && prev_valid && !prev_ready) begin
        compare("stall_valid", out_valid, 1);
        compare("stall_data", out_data, prev_data);
        compare("stall_last", out_last, prev_last);
      end
      if (out_valid) m_seen_valid = 1;
      if (m_ro_cyc == 2) compare("valid_latency", m_seen_valid, 1);
    end
  endtask

  task automatic applyStimulus(input bit a_arm, a_cont, a_trig, a_ready, a_rst, input logic [13:0] a_adc);
    bit hs;
    arm = a_arm; continuous = a_cont; trig_in = a_trig; out_ready = a_ready; rst = a_rst; adc_in = a_adc;
    hs = !a_rst && m_state == ST_RO && out_valid && a_ready;
    if (hs) begin
      compare("beat_expected", frame_q.size() > 0, 1);
      if (frame_q.size() > 0) compare("beat_data", out_data, frame_q[0]);
      compare("beat_last", out_last, m_ro_n == DEPTH - 1);
      got.push_back(out_data);
      got_last.push_back(out_last);
    end
    prev_in_ro = !a_rst && m_state == ST_RO;
    prev_valid = out_valid; prev_data = out_data; prev_last = out_last; prev_ready = a_ready;
    model_step(a_arm, a_cont, a_trig, a_rst, a_adc, hs);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // One or more frames with a ramp on adc_in restarting at 0 at each PRELOAD entry.
  task automatic do_frame(input int trig_at, input bit noise, input int ready_mode,
                          input int n_frames, input bit arm_noise, input int rst_at);
    int ramp = 0, cyc = 0, rcyc = 0, f0;
    bit wp, t, r, c, a, rs;
    got.delete(); got_last.delete();
    f0 = m_frames; hold_cycles = 0; armed_cycles = 0; trig_pulses = 0;
    applyStimulus(1'b1, n_frames > 1, 1'b0, 1'b1, 1'b0, 14'd0);
    while (m_state != ST_IDLE && cyc < 400 * n_frames) begin
      wp = (m_state == ST_PRE) || (m_state == ST_ARM) || (m_state == ST_POST);
      if (!wp) ramp = 0;
      t = wp && trig_at >= 0 && (ramp == trig_at ||
          (noise && (ramp == 1 || ramp == 3 || ramp == trig_at + 3 || ramp == trig_at + 5)));
      case (ready_mode)
        0: r = 1'b1;
        1: r = (rcyc % 4 == 0) || (rcyc % 4 == 3);
        2: r = $urandom_range(0, 1) == 1;
        default: r = 1'b0;
      endcase
      if (m_state == ST_RO) rcyc++;
      c = ((m_frames - f0) < n_frames - 1) || (m_state == ST_HOLD);
      a = arm_noise && ($urandom_range(0, 2) == 0);
      rs = rst_at > 0 && m_state == ST_RO && m_ro_cyc == rst_at;
      applyStimulus(a, c, t, r, rs, wp ? 14'(ramp) : 14'd0);
      if (wp) ramp++;
      if (state_o == 3'd5) hold_cycles++;
      if (state_o == 3'd2) armed_cycles++;
      if (triggered) trig_pulses++;
      cyc++;
      if (rs) break;
    end
    compare("frame_end_idle", m_state, ST_IDLE);
  endtask

  task automatic check_ramp(input string name, input int base, input int n_frames);
    compare({name, "_count"}, got.size(), DEPTH * n_frames);
    for (int i = 0; i < got.size(); i++) begin
      compare({name, "_data"}, got[i], base + (i % DEPTH));
      compare({name, "_last"}, got_last[i], (i % DEPTH) == DEPTH - 1);
    end
  endtask

  initial begin
    rst = 1; arm = 0; continuous = 0; trig_in = 0; out_ready = 0; adc_in = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'd0);
    compare("reset_out_data", out_data, 0);
    compare("reset_out_valid", out_valid, 0);
    compare("reset_state", state_o, 0);

    $display("[TB] test 1: ramp frame, trigger at sample 10");
    do_frame(10, 1'b0, 0, 1, 1'b0, 0);
    check_ramp("t1", 6, 1);
    compare("t1_armed_cycles", armed_cycles, 7);
    compare("t1_trig_pulses", trig_pulses, 1);

    $display("[TB] test 2: stray triggers in PRELOAD and POST");
    do_frame(10, 1'b1, 0, 1, 1'b0, 0);
    check_ramp("t2", 6, 1);
    compare("t2_trig_pulses", trig_pulses, 1);

    $display("[TB] test 3: ready pattern 1,0,0,1");
    do_frame(10, 1'b0, 1, 1, 1'b0, 0);
    check_ramp("t3", 6, 1);

    $display("[TB] test 4: earliest trigger");
    do_frame(4, 1'b0, 2, 1, 1'b0, 0);
    check_ramp("t4", 0, 1);
    compare("t4_armed_cycles", armed_cycles, 1);

    $display("[TB] test 5: continuous, two frames, arm pulses while busy");
    do_frame(10, 1'b0, 0, 2, 1'b1, 0);
    check_ramp("t5", 6, 2);
    compare("t5_hold_cycles", hold_cycles, HOLDOFF);
    compare("t5_trig_pulses", trig_pulses, 2);

    $display("[TB] test 6: reset during stalled readout");
    do_frame(10, 1'b0, 3, 1, 1'b0, 3);
    compare("t6_valid", out_valid, 0);
    compare("t6_busy", busy, 0);
    compare("t6_state", state_o, 0);
    compare("t6_last", out_last, 0);
    compare("t6_beats", got.size(), 0);

`ifdef AUTO_TRIG_EN
    $display("[TB] test 7: forced trigger");
    do_frame(-1, 1'b0, 0, 1, 1'b0, 0);
    compare("t7_armed_cycles", armed_cycles, TIMEOUT);
    compare("t7_trig_pulses", trig_pulses, 1);
    check_ramp("t7", 19, 1);
`endif

    $display("[TB] random traffic");
    begin
      int f0;
      f0 = m_frames;
      for (int i = 0; i < 4000; i++) begin
        applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 499) == 0, 14'($urandom));
      end
      compare("random_frames_done", m_frames > f0 + 5, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
